// File: rtl/bpsk_pkg.sv
// Shared constants, types and saturating helpers for the BPSK Costas demodulator.
// Latency: none, package contents are purely combinational.
// Backpressure: none, nothing in here holds state.
package bpsk_pkg;

    localparam int W         = 16;
    localparam int N_STEPS   = 4096;
    localparam int A         = $clog2(N_STEPS);
    localparam int NOM_STEP  = 40;
    localparam int LPF_SHIFT = 6;
    localparam int KP_SHIFT  = 8;
    localparam int KI_SHIFT  = 14;

    localparam int ARM_W     = W + 2;
    localparam int INTEG_W   = 24;
    localparam int CORR_W    = 8;
    localparam int CORR_MAX  = NOM_STEP / 2;
    localparam int Q_OFFSET  = N_STEPS * 3 / 4;

    localparam int ARM_MAX   = (1 << (ARM_W - 1)) - 1;
    localparam int ARM_MIN   = -(1 << (ARM_W - 1));
    localparam int INTEG_MAX = (1 << (INTEG_W - 1)) - 1;
    localparam int INTEG_MIN = -(1 << (INTEG_W - 1));

    typedef logic signed [W-1:0]       sample_t;
    typedef logic [A-1:0]              angle_t;
    typedef logic signed [ARM_W-1:0]   arm_t;
    typedef logic signed [INTEG_W-1:0] acc_t;
    typedef logic signed [CORR_W-1:0]  corr_t;

    // Clamp a full-width mixer product (already rescaled) into the arm width.
    function automatic arm_t sat_arm(input logic signed [2*W-1:0] v);
        if (v > ARM_MAX)
            return arm_t'(ARM_MAX);
        else if (v < ARM_MIN)
            return arm_t'(ARM_MIN);
        else
            return v[ARM_W-1:0];
    endfunction

    // One step of the first-order arm IIR: y + (x - y) / 2^LPF_SHIFT, saturating.
    function automatic arm_t lpf_step(input arm_t y, input arm_t x);
        logic signed [ARM_W:0] diff;
        logic signed [ARM_W:0] nxt;
        diff = (ARM_W+1)'(x) - (ARM_W+1)'(y);
        nxt  = (ARM_W+1)'(y) + (diff >>> LPF_SHIFT);
        if (nxt[ARM_W] != nxt[ARM_W-1])
            return nxt[ARM_W] ? arm_t'(ARM_MIN) : arm_t'(ARM_MAX);
        return nxt[ARM_W-1:0];
    endfunction

endpackage

// File: rtl/costas_loop_filter.sv
// Costas phase detector (sign(I) * Q) followed by a saturating PI loop filter and step clamp.
// Latency: 1 clk from arm values to the registered NCO correction.
// Backpressure: none, evaluates every clk.
module costas_loop_filter
    import bpsk_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  arm_t  i_f,
    input  arm_t  q_f,
    output corr_t corr
);

    localparam int KI_HALF = 1 << (KI_SHIFT - 1);
    localparam int KP_HALF = 1 << (KP_SHIFT - 1);

    arm_t                    neg_q;
    arm_t                    err;
    logic signed [INTEG_W:0] integ_sum;
    logic signed [INTEG_W:0] corr_sum;
    acc_t                    integ;
    acc_t                    integ_nxt;
    corr_t                   corr_nxt;

    // Q arm carries sin(nco - input); negate it so a leading input gives a positive error,
    // then strip the data sign using the I arm.
    always_comb begin
        neg_q = (q_f == arm_t'(ARM_MIN)) ? arm_t'(ARM_MAX) : -q_f;
        err   = (i_f >= 0) ? neg_q : q_f;
    end

    // PI terms; shifts round to nearest so the floor of >>> does not leak a steady -1
    // into the integrator whenever the error dithers around zero.
    always_comb begin
        integ_sum = (INTEG_W+1)'(integ)
                  + (((INTEG_W+1)'(err) + (INTEG_W+1)'(KI_HALF)) >>> KI_SHIFT);
        corr_sum  = (INTEG_W+1)'(integ)
                  + (((INTEG_W+1)'(err) + (INTEG_W+1)'(KP_HALF)) >>> KP_SHIFT);

        if (integ_sum > INTEG_MAX)
            integ_nxt = acc_t'(INTEG_MAX);
        else if (integ_sum < INTEG_MIN)
            integ_nxt = acc_t'(INTEG_MIN);
        else
            integ_nxt = integ_sum[INTEG_W-1:0];

        if (corr_sum > CORR_MAX)
            corr_nxt = corr_t'(CORR_MAX);
        else if (corr_sum < -CORR_MAX)
            corr_nxt = corr_t'(-CORR_MAX);
        else
            corr_nxt = corr_sum[CORR_W-1:0];
    end

    // Integrator state and the correction the NCO consumes on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            integ <= '0;
            corr  <= '0;
        end else begin
            integ <= integ_nxt;
            corr  <= corr_nxt;
        end
    end

endmodule

// File: rtl/bpsk_costas_demod.sv
// Coherent BPSK receiver: NCO + I/Q mixers + arm LPFs + Costas loop, hard bit decisions out.
// Latency: data_in -> data_out 3 clk plus the arm LPF group delay (~64 clk).
// Backpressure: none, accepts one sample every clk unconditionally.
module bpsk_costas_demod
    import bpsk_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic signed [W-1:0] data_in,
    output logic                data_out,
    output logic [A-1:0]        nco_i_cosine_lu_angle_steps,
    output logic [A-1:0]        nco_q_cosine_lu_angle_steps,
    input  logic signed [W-1:0] nco_carrier_i,
    input  logic signed [W-1:0] nco_carrier_q
);

    angle_t                  acc;
    angle_t                  corr_ext;
    corr_t                   corr;
    sample_t                 data_r;
    sample_t                 ci_r;
    sample_t                 cq_r;
    logic signed [2*W-1:0]   prod_i;
    logic signed [2*W-1:0]   prod_q;
    arm_t                    mix_i;
    arm_t                    mix_q;
    arm_t                    i_f;
    arm_t                    q_f;

    // Quadrature reference sits 3/4 turn ahead so the LUT cosine returns sin(phase).
    assign nco_i_cosine_lu_angle_steps = acc;
    assign nco_q_cosine_lu_angle_steps = acc + angle_t'(Q_OFFSET);
    assign corr_ext = {{(A-CORR_W){corr[CORR_W-1]}}, corr};

    // Phase accumulator; wrapping modulo N_STEPS is the intended behaviour.
    always_ff @(posedge clk) begin
        if (!rst_n)
            acc <= '0;
        else
            acc <= acc + angle_t'(NOM_STEP) + corr_ext;
    end

    // Register the sample and the LUT carriers together so they stay phase-aligned.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_r <= '0;
            ci_r   <= '0;
            cq_r   <= '0;
        end else begin
            data_r <= data_in;
            ci_r   <= nco_carrier_i;
            cq_r   <= nco_carrier_q;
        end
    end

    // Mixers: full product rescaled back to carrier full scale, saturated to arm width.
    always_comb begin
        prod_i = (2*W)'(data_r) * (2*W)'(ci_r);
        prod_q = (2*W)'(data_r) * (2*W)'(cq_r);
        mix_i  = sat_arm(prod_i >>> (W - 2));
        mix_q  = sat_arm(prod_q >>> (W - 2));
    end

    // Arm low-pass filters remove the double-frequency mixer term.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_f <= '0;
            q_f <= '0;
        end else begin
            i_f <= lpf_step(i_f, mix_i);
            q_f <= lpf_step(q_f, mix_q);
        end
    end

    // Hard decision on the filtered I arm; the 180-degree lock ambiguity is left downstream.
    always_ff @(posedge clk) begin
        if (!rst_n)
            data_out <= 1'b0;
        else
            data_out <= i_f[ARM_W-1];
    end

    costas_loop_filter u_lf (
        .clk   (clk),
        .rst_n (rst_n),
        .i_f   (i_f),
        .q_f   (q_f),
        .corr  (corr)
    );

endmodule

// File: tb/tb_bpsk_costas_demod.sv
// Directed bench for bpsk_costas_demod: reset state, lock from several offsets, data decisions.
// Latency: bench drives one sample per clk and samples outputs 1 time unit after posedge.
// Backpressure: none, the DUT always accepts data.
module tb_bpsk_costas_demod;

    localparam int    NOM         = 40;
    localparam int    SPS         = 1000;
    localparam int    WIN         = 50;
    localparam int    LOCK_TOL    = 40;
    localparam int    LOCK_HOLD   = 300;
    localparam int    LOCK_BUDGET = 20000;
    localparam int    RUN_LOCKED  = 2000;
    localparam int    N_SYMBOLS   = 25;
    localparam real   PI          = 3.14159265358979;

    typedef struct {
        int offset;
        int exp_lock;
        int exp_dout_changes;
        int exp_bad_steps;
        int exp_integ_sat;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [15:0] data_in;
    logic               data_out;
    logic [11:0]        nco_i_ang;
    logic [11:0]        nco_q_ang;
    logic signed [15:0] carrier_i;
    logic signed [15:0] carrier_q;
    logic signed [15:0] cos_tab [0:4095];

    int          total = 0;
    int          bad   = 0;
    logic [11:0] tx_acc;
    logic [11:0] tx_off;
    logic [11:0] tx_ang;
    logic [11:0] e12;
    int          s_err;
    bit          mod_on;
    bit          cur_bit;
    int          sym_cnt;

    always #5 clk = ~clk;

    // Shared cosine table serving the DUT's two NCO read ports.
    assign carrier_i = cos_tab[nco_i_ang];
    assign carrier_q = cos_tab[nco_q_ang];

    bpsk_costas_demod dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .data_in                     (data_in),
        .data_out                    (data_out),
        .nco_i_cosine_lu_angle_steps (nco_i_ang),
        .nco_q_cosine_lu_angle_steps (nco_q_ang),
        .nco_carrier_i               (carrier_i),
        .nco_carrier_q               (carrier_q)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock, then prepare the next TX sample and measure phase error.
    task automatic step();
        logic [10:0] f;
        @(posedge clk);
        #1;
        tx_acc = tx_acc + 12'(NOM);
        if (mod_on) begin
            if (sym_cnt == SPS - 1) begin
                sym_cnt = 0;
                cur_bit = 1'($urandom_range(0, 1));
            end else begin
                sym_cnt = sym_cnt + 1;
            end
        end
        tx_ang  = tx_acc + tx_off;
        data_in = cur_bit ? -cos_tab[tx_ang] : cos_tab[tx_ang];
        e12     = tx_ang - nco_i_ang;
        f       = e12[10:0];
        s_err   = (f >= 11'd1024) ? int'(f) - 2048 : int'(f);
    endtask

    task automatic do_reset(input int n, input logic [11:0] off);
        rst_n  = 1'b0;
        tx_acc = '0;
        tx_off = off;
        repeat (n) step();
        rst_n = 1'b1;
    endtask

    // Lock = phase error (averaged over one double-frequency ripple period) within
    // tolerance of 0 or pi for LOCK_HOLD consecutive cycles.
    task automatic wait_lock(input int budget, output bit ok, output bit at_pi);
        int win [WIN];
        int wsum   = 0;
        int widx   = 0;
        int consec = 0;
        ok    = 1'b0;
        at_pi = 1'b0;
        for (int k = 0; k < WIN; k++) win[k] = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            step();
            wsum      = wsum - win[widx] + s_err;
            win[widx] = s_err;
            widx      = (widx + 1) % WIN;
            if (n >= WIN && wsum < LOCK_TOL * WIN && wsum > -LOCK_TOL * WIN)
                consec++;
            else
                consec = 0;
            if (consec >= LOCK_HOLD) begin
                ok    = 1'b1;
                at_pi = (e12 >= 12'd1024) && (e12 < 12'd3072);
            end
        end
    endtask

    task automatic run_locked(input int n, output int bad_steps, output int wraps,
                              output int dout_changes, output int integ_sat);
        logic [11:0] prev;
        logic [11:0] delta;
        logic        prev_d;
        bad_steps    = 0;
        wraps        = 0;
        dout_changes = 0;
        integ_sat    = 0;
        prev   = nco_i_ang;
        prev_d = data_out;
        for (int k = 0; k < n; k++) begin
            step();
            delta = nco_i_ang - prev;
            if (delta < 12'(NOM - NOM / 2) || delta > 12'(NOM + NOM / 2)) bad_steps++;
            if (nco_i_ang < prev) wraps++;
            if (data_out != prev_d) dout_changes++;
            if (dut.u_lf.integ == 24'sh7FFFFF || dut.u_lf.integ == 24'sh800000) integ_sat++;
            prev   = nco_i_ang;
            prev_d = data_out;
        end
    endtask

    initial begin
        vec_t vecs [5];
        bit   ok;
        bit   at_pi;
        int   bad_steps;
        int   wraps;
        int   dout_changes;
        int   integ_sat;
        int   rst_bad_i;
        int   rst_bad_q;
        int   rst_bad_d;
        int   nsamp;
        int   bit_errs;

        for (int k = 0; k < 4096; k++)
            cos_tab[k] = 16'($rtoi($floor(16384.0 * $cos(2.0 * PI * real'(k) / 4096.0) + 0.5)));

        vecs[0] = '{offset: 0,    exp_lock: 1, exp_dout_changes: 0, exp_bad_steps: 0, exp_integ_sat: 0};
        vecs[1] = '{offset: 1024, exp_lock: 1, exp_dout_changes: 0, exp_bad_steps: 0, exp_integ_sat: 0};
        vecs[2] = '{offset: 2048, exp_lock: 1, exp_dout_changes: 0, exp_bad_steps: 0, exp_integ_sat: 0};
        vecs[3] = '{offset: 3071, exp_lock: 1, exp_dout_changes: 0, exp_bad_steps: 0, exp_integ_sat: 0};
        vecs[4] = '{offset: 1235, exp_lock: 1, exp_dout_changes: 0, exp_bad_steps: 0, exp_integ_sat: 0};

        rst_n   = 1'b0;
        data_in = '0;
        tx_acc  = '0;
        tx_off  = '0;
        mod_on  = 1'b0;
        cur_bit = 1'b0;
        sym_cnt = 0;

        // Reset held 100 cycles: angles 0 / 3072 and data_out low throughout.
        rst_bad_i = 0;
        rst_bad_q = 0;
        rst_bad_d = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (nco_i_ang != 12'd0)    rst_bad_i++;
            if (nco_q_ang != 12'd3072) rst_bad_q++;
            if (data_out != 1'b0)      rst_bad_d++;
        end
        check("rst_i_angle", int'(nco_i_ang), 0);
        check("rst_q_angle", int'(nco_q_ang), 3072);
        check("rst_data_out", int'(data_out), 0);
        check("rst_hold_i_cycles_bad", rst_bad_i, 0);
        check("rst_hold_q_cycles_bad", rst_bad_q, 0);
        check("rst_hold_dout_cycles_bad", rst_bad_d, 0);

        // Unmodulated carrier at several TX phase offsets.
        for (int v = 0; v < 5; v++) begin
            do_reset(5, 12'(vecs[v].offset));
            wait_lock(LOCK_BUDGET, ok, at_pi);
            check($sformatf("lock_off%0d", vecs[v].offset), int'(ok), vecs[v].exp_lock);
            run_locked(RUN_LOCKED, bad_steps, wraps, dout_changes, integ_sat);
            check($sformatf("dout_level_off%0d", vecs[v].offset), int'(data_out), int'(at_pi));
            check($sformatf("dout_changes_off%0d", vecs[v].offset), dout_changes, vecs[v].exp_dout_changes);
            check($sformatf("nco_step_off%0d", vecs[v].offset), bad_steps, vecs[v].exp_bad_steps);
            check($sformatf("nco_wrap_seen_off%0d", vecs[v].offset), int'(wraps > 0), 1);
            check($sformatf("integ_sat_off%0d", vecs[v].offset), integ_sat, vecs[v].exp_integ_sat);
        end

        // One-cycle reset in the middle of a locked run, then reacquire.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst_i_angle", int'(nco_i_ang), 0);
        check("midrst_q_angle", int'(nco_q_ang), 3072);
        check("midrst_data_out", int'(data_out), 0);
        check("midrst_integ", int'(dut.u_lf.integ), 0);
        wait_lock(LOCK_BUDGET, ok, at_pi);
        check("midrst_relock", int'(ok), 1);

        // Random BPSK symbols: mid-symbol decisions match bit (or ~bit if locked at pi).
        mod_on  = 1'b1;
        sym_cnt = 0;
        cur_bit = 1'($urandom_range(0, 1));
        do_reset(5, 12'd700);
        wait_lock(LOCK_BUDGET, ok, at_pi);
        check("mod_lock", int'(ok), 1);
        nsamp    = 0;
        bit_errs = 0;
        for (int k = 0; k < N_SYMBOLS * SPS; k++) begin
            step();
            if (sym_cnt == SPS / 2) begin
                nsamp++;
                if (data_out != (cur_bit ^ at_pi)) bit_errs++;
            end
        end
        check("mod_samples", nsamp, N_SYMBOLS);
        check("mod_bit_errors", bit_errs, 0);
        mod_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
